// File: rtl/fetch_stage_if.sv
// Fetch stage boundary: control inputs, instruction bus, decode-side delivery.
// master = fetch stage, slave = surrounding pipeline/bus.
interface fetch_stage_if #(
    parameter int XLEN = 64
);
    logic            stall;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_data_ok;
    logic [31:0]     iresp_data;
    logic            fetch_valid;
    logic [XLEN-1:0] fetch_pc;
    logic [31:0]     fetch_instr;
    logic            fetch_busy;

    modport master (
        input  stall, flush, redirect_pc,
        input  iresp_data_ok, iresp_data,
        output ireq_valid, ireq_addr,
        output fetch_valid, fetch_pc, fetch_instr, fetch_busy
    );

    modport slave (
        output stall, flush, redirect_pc,
        output iresp_data_ok, iresp_data,
        input  ireq_valid, ireq_addr,
        input  fetch_valid, fetch_pc, fetch_instr, fetch_busy
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, issues bus requests and hands
// one instruction per response to decode, honouring stall and flush.
module fetch_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master fif
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DISCARD
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [31:0]     buf_q, buf_d;

    logic [XLEN-1:0] redir;
    logic [XLEN-1:0] pc_inc;

    assign redir  = {fif.redirect_pc[XLEN-1:2], 2'b00};
    assign pc_inc = pc_q + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (fif.flush) pc_d = redir;
            end
            S_REQ: begin
                if (fif.iresp_data_ok) begin
                    if (fif.flush) begin
                        pc_d = redir;
                    end else if (fif.stall) begin
                        buf_d   = fif.iresp_data;
                        state_d = S_HOLD;
                    end else begin
                        pc_d = pc_inc;
                    end
                end else if (fif.flush) begin
                    // request stays on the bus; remember its address
                    addr_d  = pc_q;
                    pc_d    = redir;
                    state_d = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (fif.flush) begin
                    pc_d    = redir;
                    state_d = S_REQ;
                end else if (!fif.stall) begin
                    pc_d    = pc_inc;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (fif.flush) pc_d = redir;
                if (fif.iresp_data_ok) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    logic            req_valid;
    logic [XLEN-1:0] req_addr;
    logic            f_valid;
    logic [XLEN-1:0] f_pc;
    logic [31:0]     f_instr;
    logic            f_busy;

    // reset masks outputs in the same cycle so a late response is never seen
    always_comb begin
        req_valid = 1'b0;
        req_addr  = pc_q;
        f_valid   = 1'b0;
        f_pc      = pc_q;
        f_instr   = '0;
        f_busy    = 1'b0;
        if (reset) begin
            req_addr = RESET_PC;
            f_pc     = RESET_PC;
            f_busy   = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    f_busy = 1'b1;
                end
                S_REQ: begin
                    req_valid = 1'b1;
                    f_valid   = fif.iresp_data_ok;
                    f_instr   = fif.iresp_data;
                    f_busy    = !fif.iresp_data_ok;
                end
                S_HOLD: begin
                    f_valid = 1'b1;
                    f_instr = buf_q;
                end
                S_DISCARD: begin
                    req_valid = 1'b1;
                    req_addr  = addr_q;
                    f_busy    = 1'b1;
                end
                default: f_busy = 1'b1;
            endcase
        end
    end

    assign fif.ireq_valid  = req_valid;
    assign fif.ireq_addr   = req_addr;
    assign fif.fetch_valid = f_valid;
    assign fif.fetch_pc    = f_pc;
    assign fif.fetch_instr = f_instr;
    assign fif.fetch_busy  = f_busy;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors, corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_fetch_stage;
    localparam int          XLEN = 64;
    localparam logic [63:0] RPC  = 64'h8000_0000;
    localparam logic [63:0] WRP  = 64'hFFFF_FFFF_FFFF_FFFC;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(XLEN)) fif ();

    fetch_stage #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
        .clk  (clk),
        .reset(reset),
        .fif  (fif.master)
    );

    typedef struct {
        bit          rst;
        bit          stall;
        bit          flush;
        logic [63:0] rpc;
        bit          dok;
        logic [31:0] data;
        bit          e_req;
        logic [63:0] e_addr;
        bit          e_fv;
        logic [63:0] e_pc;
        logic [31:0] e_instr;
        bit          e_busy;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    function automatic vec_t mk(
        bit r, bit s, bit f, logic [63:0] rpc, bit dok, logic [31:0] d,
        bit req, logic [63:0] addr, bit fv, logic [63:0] pc,
        logic [31:0] ins, bit busy);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.rpc = rpc;
        v.dok = dok; v.data = d;
        v.e_req = req; v.e_addr = addr; v.e_fv = fv;
        v.e_pc = pc; v.e_instr = ins; v.e_busy = busy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset             = v.rst;
        fif.stall         = v.stall;
        fif.flush         = v.flush;
        fif.redirect_pc   = v.rpc;
        fif.iresp_data_ok = v.dok;
        fif.iresp_data    = v.data;
    endtask

    // address only matters while requesting; instr only when delivered or idle
    task automatic compare(input string name, input vec_t v);
        bit ok;
        ok = (fif.ireq_valid === v.e_req) && (fif.fetch_valid === v.e_fv) &&
             (fif.fetch_busy === v.e_busy) && (fif.fetch_pc === v.e_pc) &&
             (!v.e_req || fif.ireq_addr === v.e_addr) &&
             ((v.e_req && !v.e_fv) || fif.fetch_instr === v.e_instr);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got req=%0b addr=%h fv=%0b pc=%h instr=%h busy=%0b want req=%0b addr=%h fv=%0b pc=%h instr=%h busy=%0b",
                     name, fif.ireq_valid, fif.ireq_addr, fif.fetch_valid,
                     fif.fetch_pc, fif.fetch_instr, fif.fetch_busy,
                     v.e_req, v.e_addr, v.e_fv, v.e_pc, v.e_instr, v.e_busy);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        compare(name, v);
    endtask

    // transaction-level reference
    bit          m_idle, m_hold, m_drop;
    logic [63:0] m_pc, m_addr;
    logic [31:0] m_buf;
    int          m_age;

    function automatic logic [63:0] al(logic [63:0] a);
        return a & ~64'h3;
    endfunction

    task automatic model_expect(inout vec_t v);
        if (v.rst) begin
            v.e_req = 0; v.e_addr = RPC; v.e_fv = 0;
            v.e_pc = RPC; v.e_instr = 0; v.e_busy = 1;
        end else if (m_idle) begin
            v.e_req = 0; v.e_addr = m_pc; v.e_fv = 0;
            v.e_pc = m_pc; v.e_instr = 0; v.e_busy = 1;
        end else if (m_hold) begin
            v.e_req = 0; v.e_addr = m_pc; v.e_fv = 1;
            v.e_pc = m_pc; v.e_instr = m_buf; v.e_busy = 0;
        end else if (m_drop) begin
            v.e_req = 1; v.e_addr = m_addr; v.e_fv = 0;
            v.e_pc = m_pc; v.e_instr = 0; v.e_busy = 1;
        end else begin
            v.e_req = 1; v.e_addr = m_pc; v.e_fv = v.dok;
            v.e_pc = m_pc; v.e_instr = v.data; v.e_busy = !v.dok;
        end
    endtask

    task automatic model_update(input vec_t v);
        if (v.rst) begin
            m_idle = 1; m_hold = 0; m_drop = 0;
            m_pc = RPC; m_addr = RPC; m_buf = 0; m_age = 0;
        end else if (m_idle) begin
            if (v.flush) m_pc = al(v.rpc);
            m_idle = 0; m_age = 0;
        end else if (m_hold) begin
            if (v.flush) begin
                m_pc = al(v.rpc); m_hold = 0;
            end else if (!v.stall) begin
                m_pc = m_pc + 64'd4; m_hold = 0;
            end
            m_age = 0;
        end else if (m_drop) begin
            if (v.flush) m_pc = al(v.rpc);
            if (v.dok) begin
                m_drop = 0; m_age = 0;
            end else begin
                m_age++;
            end
        end else if (v.dok) begin
            if (v.flush) m_pc = al(v.rpc);
            else if (v.stall) begin
                m_buf = v.data; m_hold = 1;
            end else m_pc = m_pc + 64'd4;
            m_age = 0;
        end else begin
            if (v.flush) begin
                m_addr = m_pc; m_pc = al(v.rpc); m_drop = 1;
            end
            m_age++;
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t v;
        reset = 1'b1;
        fif.stall = 0; fif.flush = 0; fif.redirect_pc = '0;
        fif.iresp_data_ok = 0; fif.iresp_data = '0;

        // streaming fetch, then a stalled response held for several cycles
        tbl.push_back(mk(1,0,0,0,0,0,        0,RPC,0,RPC,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,        0,RPC,0,RPC,0,1));
        tbl.push_back(mk(0,0,0,0,0,0,        1,RPC,0,RPC,0,1));
        tbl.push_back(mk(0,0,0,0,1,32'h11,   1,RPC,1,RPC,32'h11,0));
        tbl.push_back(mk(0,0,0,0,0,0,        1,RPC+4,0,RPC+4,0,1));
        tbl.push_back(mk(0,0,0,0,1,32'h22,   1,RPC+4,1,RPC+4,32'h22,0));
        tbl.push_back(mk(0,0,0,0,0,0,        1,RPC+8,0,RPC+8,0,1));
        tbl.push_back(mk(0,1,0,0,1,32'h13,   1,RPC+8,1,RPC+8,32'h13,0));
        tbl.push_back(mk(0,1,0,0,0,0,        0,RPC+8,1,RPC+8,32'h13,0));
        tbl.push_back(mk(0,1,0,0,0,0,        0,RPC+8,1,RPC+8,32'h13,0));
        tbl.push_back(mk(0,1,0,0,0,0,        0,RPC+8,1,RPC+8,32'h13,0));
        tbl.push_back(mk(0,0,0,0,0,0,        0,RPC+8,1,RPC+8,32'h13,0));
        tbl.push_back(mk(0,0,0,0,0,0,        1,RPC+12,0,RPC+12,0,1));
        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // flush with a request outstanding: old address held until data_ok
        step("t3_rst",   mk(1,0,0,0,0,0,            0,RPC,0,RPC,0,1));
        step("t3_idle",  mk(0,0,0,0,0,0,            0,RPC,0,RPC,0,1));
        step("t3_r0",    mk(0,0,0,0,0,0,            1,RPC,0,RPC,0,1));
        step("t3_d0",    mk(0,0,0,0,1,1,            1,RPC,1,RPC,1,0));
        step("t3_r4",    mk(0,0,0,0,0,0,            1,RPC+4,0,RPC+4,0,1));
        step("t3_d4",    mk(0,0,0,0,1,2,            1,RPC+4,1,RPC+4,2,0));
        step("t3_flush", mk(0,0,1,RPC+'h100,0,0,    1,RPC+8,0,RPC+8,0,1));
        step("t3_disc",  mk(0,0,0,0,0,0,            1,RPC+8,0,RPC+'h100,0,1));
        step("t3_drop",  mk(0,0,0,0,1,32'hdead,     1,RPC+8,0,RPC+'h100,0,1));
        step("t3_redir", mk(0,0,0,0,0,0,            1,RPC+'h100,0,RPC+'h100,0,1));
        // two flushes while discarding, low bits of target masked
        step("t5_f1",    mk(0,0,1,RPC+'h203,0,0,    1,RPC+'h100,0,RPC+'h100,0,1));
        step("t5_f2",    mk(0,0,1,RPC+'h300,0,0,    1,RPC+'h100,0,RPC+'h200,0,1));
        step("t5_drop",  mk(0,0,0,0,1,32'hbad,      1,RPC+'h100,0,RPC+'h300,0,1));
        step("t5_req",   mk(0,0,0,0,0,0,            1,RPC+'h300,0,RPC+'h300,0,1));
        // flush and stall together while holding
        step("t4_stall", mk(0,1,0,0,1,32'h44,       1,RPC+'h300,1,RPC+'h300,32'h44,0));
        step("t4_fs",    mk(0,1,1,RPC+'h400,0,0,    0,RPC,1,RPC+'h300,32'h44,0));
        step("t4_req",   mk(0,1,0,0,0,0,            1,RPC+'h400,0,RPC+'h400,0,1));
        // reset with a response arriving during it
        step("t6_rst",   mk(1,0,0,0,1,32'h55,       0,RPC,0,RPC,0,1));
        step("t6_idle",  mk(0,0,0,0,1,32'h66,       0,RPC,0,RPC,0,1));
        step("t6_req",   mk(0,0,0,0,0,0,            1,RPC,0,RPC,0,1));
        // pc+4 wraps at the top of the address space
        step("wr_flush", mk(0,0,1,'1,0,0,           1,RPC,0,RPC,0,1));
        step("wr_drop",  mk(0,0,0,0,1,0,            1,RPC,0,WRP,0,1));
        step("wr_req",   mk(0,0,0,0,0,0,            1,WRP,0,WRP,0,1));
        step("wr_dok",   mk(0,0,0,0,1,32'h77,       1,WRP,1,WRP,32'h77,0));
        step("wr_zero",  mk(0,0,0,0,0,0,            1,0,0,0,0,1));
        step("dok_fl",   mk(0,0,1,RPC+'h500,1,32'h88, 1,0,1,0,32'h88,0));
        step("dok_fl2",  mk(0,0,0,0,0,0,            1,RPC+'h500,0,RPC+'h500,0,1));

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            v.rst   = (i == 0) || ($urandom_range(0, 49) == 0);
            v.stall = ($urandom_range(0, 2) == 0);
            v.flush = ($urandom_range(0, 5) == 0);
            v.rpc   = {$urandom, $urandom};
            v.data  = $urandom;
            if (!m_idle && !m_hold && m_age >= 1)
                v.dok = $urandom_range(0, 1) == 1;
            else if (m_idle)
                v.dok = $urandom_range(0, 3) == 0;
            else
                v.dok = 0;
            drive(v);
            #1;
            model_expect(v);
            compare("rand", v);
            model_update(v);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
